// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser: coin table, coin indices and FSM encoding.
package vend_pkg;

  localparam int NUM_COINS = 5;

  localparam logic [2:0] COIN_100 = 3'd0;
  localparam logic [2:0] COIN_25  = 3'd1;
  localparam logic [2:0] COIN_10  = 3'd2;
  localparam logic [2:0] COIN_5   = 3'd3;
  localparam logic [2:0] COIN_1   = 3'd4;

  localparam int unsigned COIN_VALUE [NUM_COINS] = '{100, 25, 10, 5, 1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_DONE
  } state_e;

  // Out-of-range indices map to 0 so a stray index can never subtract anything.
  function automatic int unsigned coin_value(input logic [2:0] idx);
    coin_value = (idx < 3'(NUM_COINS)) ? COIN_VALUE[idx] : 32'd0;
  endfunction

endpackage

// File: rtl/vend_coin_select.sv
// Combinational largest-coin-first picker: finds the biggest coin that fits the
// remaining amount and still has stock.
module vend_coin_select
  import vend_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]         rem_i,
  input  logic [NUM_COINS-1:0] inv_empty_i,
  output logic                 found_o,
  output logic [2:0]           idx_o
);

  // Scan smallest to largest so the last hit, the largest coin, wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = 3'd0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (!inv_empty_i[i] && (rem_i >= W'(COIN_VALUE[i]))) begin
        found_o = 1'b1;
        idx_o   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/vend_change_dispenser.sv
// Coin return sequencer: drives the hopper one coin at a time, tracks per-coin
// inventory and reports shortfall and hopper timeouts.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int W        = 16,
  parameter int INV_W    = 8,
  parameter int INIT_CNT = 20,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [W-1:0]         amount_i,
  input  logic                 load_i,
  input  logic [2:0]           load_sel_i,
  input  logic [INV_W-1:0]     load_cnt_i,
  input  logic                 eject_ack_i,
  output logic                 eject_req_o,
  output logic [2:0]           eject_sel_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [W-1:0]         short_o,
  output logic                 err_o,
  output logic [NUM_COINS-1:0] inv_empty_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                 state_q, state_d;
  logic [W-1:0]           rem_q;
  logic [W-1:0]           short_q;
  logic                   err_q;
  logic [2:0]             sel_q;
  logic [TW-1:0]          timer_q;
  logic [INV_W-1:0]       inv_q [NUM_COINS];
  logic [NUM_COINS-1:0]   inv_empty;
  logic                   pick_found;
  logic [2:0]             pick_idx;
  logic                   accept, acked, timed_out;

  always_comb begin
    for (int i = 0; i < NUM_COINS; i++) begin
      inv_empty[i] = (inv_q[i] == '0);
    end
  end

  vend_coin_select #(.W(W)) u_select (
    .rem_i       (rem_q),
    .inv_empty_i (inv_empty),
    .found_o     (pick_found),
    .idx_o       (pick_idx)
  );

  assign accept    = (state_q == S_IDLE) && start_i;
  assign acked     = (state_q == S_REQ) && eject_ack_i;
  assign timed_out = (state_q == S_REQ) && !eject_ack_i && (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = (amount_i != '0) ? S_SELECT : S_DONE;
      S_SELECT: state_d = (rem_q != '0 && pick_found) ? S_REQ : S_DONE;
      S_REQ: begin
        if (acked)          state_d = S_SELECT;
        else if (timed_out) state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    eject_req_o = 1'b0;
    eject_sel_o = 3'd0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      S_SELECT: busy_o = 1'b1;
      S_REQ: begin
        busy_o      = 1'b1;
        eject_req_o = 1'b1;
        eject_sel_o = sel_q;
      end
      S_DONE:   done_o = 1'b1;
      default:  ;
    endcase
  end

  // Inventory loads share the IDLE cycle with a start, so SELECT already sees them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q   <= '0;
      short_q <= '0;
      err_q   <= 1'b0;
      sel_q   <= 3'd0;
      timer_q <= '0;
      for (int i = 0; i < NUM_COINS; i++) inv_q[i] <= INV_W'(INIT_CNT);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rem_q   <= amount_i;
            short_q <= '0;
            err_q   <= 1'b0;
          end
          if (load_i && (load_sel_i < 3'(NUM_COINS))) inv_q[load_sel_i] <= load_cnt_i;
        end
        S_SELECT: begin
          timer_q <= '0;
          if (pick_found) sel_q <= pick_idx;
          else if (rem_q != '0) short_q <= rem_q;
        end
        S_REQ: begin
          if (acked) begin
            rem_q   <= rem_q - W'(coin_value(sel_q));
            timer_q <= '0;
            if (inv_q[sel_q] != '0) inv_q[sel_q] <= inv_q[sel_q] - 1'b1;
          end else if (timed_out) begin
            err_q   <= 1'b1;
            short_q <= rem_q;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign short_o     = short_q;
  assign err_o       = err_q;
  assign inv_empty_o = inv_empty;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Randomised and directed bench for the change dispenser, checked against a
// greedy change model that keeps its own inventory.
module tb_vend_change_dispenser;

  localparam int W        = 16;
  localparam int INV_W    = 8;
  localparam int INIT_CNT = 20;
  localparam int TIMEOUT  = 255;
  localparam int VALUES [5] = '{100, 25, 10, 5, 1};

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic             start_i = 1'b0;
  logic [W-1:0]     amount_i = '0;
  logic             load_i = 1'b0;
  logic [2:0]       load_sel_i = 3'd0;
  logic [INV_W-1:0] load_cnt_i = '0;
  logic             eject_ack_i = 1'b0;
  logic             eject_req_o;
  logic [2:0]       eject_sel_o;
  logic             busy_o;
  logic             done_o;
  logic [W-1:0]     short_o;
  logic             err_o;
  logic [4:0]       inv_empty_o;

  int checks = 0;
  int failures = 0;
  int inv_m [5];
  int exp_coins [$];
  int exp_short;
  int sel_log [$];
  int req_cycles, busy_cycles, done_pulses;

  always #5 clk_i = ~clk_i;

  vend_change_dispenser #(
    .W(W), .INV_W(INV_W), .INIT_CNT(INIT_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .amount_i    (amount_i),
    .load_i      (load_i),
    .load_sel_i  (load_sel_i),
    .load_cnt_i  (load_cnt_i),
    .eject_ack_i (eject_ack_i),
    .eject_req_o (eject_req_o),
    .eject_sel_o (eject_sel_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .short_o     (short_o),
    .err_o       (err_o),
    .inv_empty_o (inv_empty_o)
  );

  // Observe the hopper interface mid-cycle, away from the active edge.
  always @(negedge clk_i) begin
    if (eject_req_o && eject_ack_i) sel_log.push_back(int'(eject_sel_o));
    if (eject_req_o) req_cycles++;
    if (busy_o) busy_cycles++;
    if (done_o) done_pulses++;
  end

  // Greedy change: largest coin first, each denomination used while it fits and is stocked.
  function automatic void model_dispense(input int amount);
    int rem;
    rem = amount;
    exp_coins.delete();
    for (int d = 0; d < 5; d++) begin
      while (rem >= VALUES[d] && inv_m[d] > 0) begin
        exp_coins.push_back(d);
        rem -= VALUES[d];
        inv_m[d]--;
      end
    end
    exp_short = rem;
  endfunction

  function automatic logic [4:0] model_empty();
    logic [4:0] e;
    for (int d = 0; d < 5; d++) e[d] = (inv_m[d] == 0);
    return e;
  endfunction

  function automatic string q_str(input int q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%0d,", q[i])};
    return s;
  endfunction

  task automatic apply_reset();
    start_i = 1'b0;
    load_i  = 1'b0;
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int d = 0; d < 5; d++) inv_m[d] = INIT_CNT;
  endtask

  task automatic load_inv(input int sel, input int cnt);
    @(posedge clk_i); #1;
    load_i = 1'b1; load_sel_i = 3'(sel); load_cnt_i = INV_W'(cnt);
    @(posedge clk_i); #1;
    load_i = 1'b0;
    if (sel < 5) inv_m[sel] = cnt;
  endtask

  task automatic drive_start(input int amount);
    @(posedge clk_i); #1;
    sel_log.delete();
    req_cycles = 0; busy_cycles = 0; done_pulses = 0;
    start_i = 1'b1; amount_i = W'(amount);
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < bound) begin
      @(negedge clk_i);
      lat++;
      if (done_o) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk_i);
    checks++;
    if ({eject_req_o, eject_sel_o, busy_o, done_o, err_o} !== 7'd0 || short_o !== '0)
      $display("[TB] FAIL reset_outputs: got req=%0b sel=%0d busy=%0b done=%0b err=%0b short=%0d expected all 0",
               eject_req_o, eject_sel_o, busy_o, done_o, err_o, short_o);
    checks++;
    if (inv_empty_o !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_inv_empty: got %b expected 00000", inv_empty_o);
    end
    if ({eject_req_o, eject_sel_o, busy_o, done_o, err_o} !== 7'd0 || short_o !== '0) failures++;
  endtask

  task automatic test_basic_41();
    int lat; bit got;
    eject_ack_i = 1'b1;
    model_dispense(41);
    drive_start(41);
    wait_done(200, lat, got);
    checks++;
    if (!got || q_str(sel_log) != q_str(exp_coins)) begin
      failures++;
      $display("[TB] FAIL basic41_seq: got %s expected %s (done=%0b)", q_str(sel_log), q_str(exp_coins), got);
    end
    checks++;
    if (lat !== 2 * exp_coins.size() + 2) begin
      failures++;
      $display("[TB] FAIL basic41_latency: got %0d expected %0d", lat, 2 * exp_coins.size() + 2);
    end
    checks++;
    if (short_o !== W'(exp_short)) begin
      failures++;
      $display("[TB] FAIL basic41_short: got %0d expected %0d", short_o, exp_short);
    end
    checks++;
    if (int'(dut.inv_q[1]) !== 19) begin
      failures++;
      $display("[TB] FAIL basic41_inv25: got %0d expected 19", dut.inv_q[1]);
    end
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0 || done_pulses !== 1) begin
      failures++;
      $display("[TB] FAIL basic41_done_width: got done=%0b pulses=%0d expected 0 and 1", done_o, done_pulses);
    end
  endtask

  task automatic test_zero_amount();
    int lat; bit got;
    drive_start(0);
    wait_done(20, lat, got);
    @(negedge clk_i);
    checks++;
    if (!got || lat !== 1) begin
      failures++;
      $display("[TB] FAIL zero_latency: got %0d (done=%0b) expected 1", lat, got);
    end
    checks++;
    if (req_cycles !== 0 || busy_cycles !== 0) begin
      failures++;
      $display("[TB] FAIL zero_no_activity: got req=%0d busy=%0d expected 0 and 0", req_cycles, busy_cycles);
    end
  endtask

  task automatic test_load_75();
    int lat; bit got;
    load_inv(1, 1);
    model_dispense(75);
    drive_start(75);
    wait_done(200, lat, got);
    checks++;
    if (!got || q_str(sel_log) != q_str(exp_coins)) begin
      failures++;
      $display("[TB] FAIL load75_seq: got %s expected %s", q_str(sel_log), q_str(exp_coins));
    end
    checks++;
    if (short_o !== W'(exp_short) || inv_empty_o !== model_empty()) begin
      failures++;
      $display("[TB] FAIL load75_short_empty: got short=%0d empty=%b expected %0d %b",
               short_o, inv_empty_o, exp_short, model_empty());
    end
  endtask

  task automatic test_shortage();
    int lat; bit got;
    for (int d = 0; d < 4; d++) load_inv(d, 0);
    load_inv(4, 3);
    model_dispense(7);
    drive_start(7);
    wait_done(200, lat, got);
    checks++;
    if (!got || q_str(sel_log) != q_str(exp_coins)) begin
      failures++;
      $display("[TB] FAIL short7_seq: got %s expected %s", q_str(sel_log), q_str(exp_coins));
    end
    checks++;
    if (short_o !== W'(exp_short) || err_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL short7_result: got short=%0d err=%0b expected %0d 0", short_o, err_o, exp_short);
    end
    checks++;
    if (inv_empty_o !== model_empty()) begin
      failures++;
      $display("[TB] FAIL short7_empty: got %b expected %b", inv_empty_o, model_empty());
    end
  endtask

  task automatic test_timeout();
    int lat; bit got;
    for (int d = 0; d < 5; d++) load_inv(d, INIT_CNT);
    eject_ack_i = 1'b0;
    drive_start(100);
    repeat (5) @(posedge clk_i);
    #1;
    load_i = 1'b1; load_sel_i = 3'd0; load_cnt_i = '0;
    start_i = 1'b1; amount_i = W'(5);
    @(posedge clk_i); #1;
    load_i = 1'b0; start_i = 1'b0;
    wait_done(600, lat, got);
    checks++;
    if (!got || req_cycles !== TIMEOUT) begin
      failures++;
      $display("[TB] FAIL timeout_req_cycles: got %0d (done=%0b) expected %0d", req_cycles, got, TIMEOUT);
    end
    checks++;
    if (err_o !== 1'b1 || short_o !== W'(100)) begin
      failures++;
      $display("[TB] FAIL timeout_result: got err=%0b short=%0d expected 1 100", err_o, short_o);
    end
    checks++;
    if (int'(dut.inv_q[0]) !== inv_m[0]) begin
      failures++;
      $display("[TB] FAIL timeout_inv_unchanged: got %0d expected %0d", dut.inv_q[0], inv_m[0]);
    end
    @(negedge clk_i);
    checks++;
    if (done_pulses !== 1 || busy_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_single_done: got pulses=%0d busy=%0b expected 1 0", done_pulses, busy_o);
    end
    eject_ack_i = 1'b1;
  endtask

  task automatic test_load_with_start();
    int lat; bit got;
    @(posedge clk_i); #1;
    sel_log.delete();
    req_cycles = 0; busy_cycles = 0; done_pulses = 0;
    load_i = 1'b1; load_sel_i = 3'd0; load_cnt_i = '0;
    start_i = 1'b1; amount_i = W'(100);
    @(posedge clk_i); #1;
    load_i = 1'b0; start_i = 1'b0;
    inv_m[0] = 0;
    model_dispense(100);
    wait_done(200, lat, got);
    checks++;
    if (!got || q_str(sel_log) != q_str(exp_coins)) begin
      failures++;
      $display("[TB] FAIL load_start_seq: got %s expected %s", q_str(sel_log), q_str(exp_coins));
    end
    checks++;
    if (err_o !== 1'b0 || short_o !== W'(exp_short)) begin
      failures++;
      $display("[TB] FAIL load_start_result: got err=%0b short=%0d expected 0 %0d", err_o, short_o, exp_short);
    end
  endtask

  task automatic test_load_guard();
    bit bad;
    load_inv(5, 0);
    load_inv(7, 0);
    bad = 1'b0;
    for (int d = 0; d < 5; d++) if (int'(dut.inv_q[d]) !== inv_m[d]) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL load_guard: got %0d,%0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d,%0d",
               dut.inv_q[0], dut.inv_q[1], dut.inv_q[2], dut.inv_q[3], dut.inv_q[4],
               inv_m[0], inv_m[1], inv_m[2], inv_m[3], inv_m[4]);
    end
  endtask

  task automatic test_random();
    int lat, amt; bit got;
    eject_ack_i = 1'b1;
    for (int it = 0; it < 15; it++) begin
      if ($urandom_range(0, 1) == 1) load_inv(int'($urandom_range(0, 7)), int'($urandom_range(0, 6)));
      amt = int'($urandom_range(1, 300));
      model_dispense(amt);
      drive_start(amt);
      wait_done(200, lat, got);
      checks++;
      if (!got || q_str(sel_log) != q_str(exp_coins)) begin
        failures++;
        $display("[TB] FAIL rand_seq amt=%0d: got %s expected %s", amt, q_str(sel_log), q_str(exp_coins));
      end
      checks++;
      if (lat !== 2 * exp_coins.size() + 2) begin
        failures++;
        $display("[TB] FAIL rand_latency amt=%0d: got %0d expected %0d", amt, lat, 2 * exp_coins.size() + 2);
      end
      checks++;
      if (short_o !== W'(exp_short) || err_o !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rand_result amt=%0d: got short=%0d err=%0b expected %0d 0", amt, short_o, err_o, exp_short);
      end
      checks++;
      if (inv_empty_o !== model_empty()) begin
        failures++;
        $display("[TB] FAIL rand_empty amt=%0d: got %b expected %b", amt, inv_empty_o, model_empty());
      end
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    bit bad;
    eject_ack_i = 1'b1;
    for (int d = 0; d < 5; d++) load_inv(d, INIT_CNT);
    drive_start(250);
    waited = 0;
    while (sel_log.size() < 1 && waited < 50) begin
      @(posedge clk_i);
      waited++;
    end
    #1 eject_ack_i = 1'b0;
    waited = 0;
    do begin
      @(negedge clk_i);
      waited++;
    end while (!eject_req_o && waited < 20);
    checks++;
    if (eject_req_o !== 1'b1 || sel_log.size() !== 1) begin
      failures++;
      $display("[TB] FAIL midreset_setup: got req=%0b coins=%0d expected 1 1", eject_req_o, sel_log.size());
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (eject_req_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_drop: got req=%0b busy=%0b expected 0 0", eject_req_o, busy_o);
    end
    bad = 1'b0;
    for (int d = 0; d < 5; d++) if (int'(dut.inv_q[d]) !== INIT_CNT) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL midreset_inv: got %0d,%0d,%0d,%0d,%0d expected all %0d",
               dut.inv_q[0], dut.inv_q[1], dut.inv_q[2], dut.inv_q[3], dut.inv_q[4], INIT_CNT);
    end
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int d = 0; d < 5; d++) inv_m[d] = INIT_CNT;
    repeat (4) @(negedge clk_i);
    checks++;
    if (done_pulses !== 0 || busy_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_no_done: got pulses=%0d busy=%0b expected 0 0", done_pulses, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_41();
    test_zero_amount();
    test_load_75();
    test_shortage();
    test_timeout();
    test_load_with_start();
    test_load_guard();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
